// File: rtl/safecrack_pkg.sv
// Shared types and defaults for the safe-lock button front-end.
package safecrack_pkg;

   localparam int BTN_W               = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int TIMEOUT_CYCLES_DEF  = 1000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHORD    = 2'd1,
      EMIT     = 2'd2,
      WAIT_REL = 2'd3
   } btn_enc_state_t;

endpackage

// File: rtl/safecrack_btn_debounce.sv
// One button bit: 2-flop synchronizer followed by a stable-count debouncer.
module safecrack_btn_debounce
   import safecrack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic deb
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          deb_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         deb_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
         // Any agreement with the current output restarts the stability count.
         if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign deb = deb_reg;

endmodule

// File: rtl/safecrack_btn_encoder.sv
// Merges debounced button chords into single-cycle codes for the lock FSM.
// Optional chord hold timeout is enabled by defining BTN_TIMEOUT_EN.
module safecrack_btn_encoder
   import safecrack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BTN_W-1:0] btn_raw,
   output logic [BTN_W-1:0] code,
   output logic             code_valid,
   output logic             busy,
   output logic             abort
);

   logic [BTN_W-1:0] deb;
   btn_enc_state_t   state_reg, state_next;
   logic [BTN_W-1:0] acc_reg, acc_next;
   logic [BTN_W-1:0] code_reg, code_next;
   logic             abort_next;

   genvar gi;
   generate
      for (gi = 0; gi < BTN_W; gi++) begin : g_deb
         safecrack_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[gi]),
            .deb    (deb[gi])
         );
      end
   endgenerate

`ifdef BTN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_reg;

   // Held at zero outside CHORD, so every entry into CHORD starts from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_reg <= '0;
      end else if (state_reg != CHORD) begin
         tmo_reg <= '0;
      end else if (tmo_reg != TW'(TIMEOUT_CYCLES)) begin
         tmo_reg <= tmo_reg + 1'b1;
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      code_next  = code_reg;
      abort_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (deb != '0) begin
               acc_next   = deb;
               state_next = CHORD;
            end
         end
         CHORD: begin
            acc_next = acc_reg | deb;
`ifdef BTN_TIMEOUT_EN
            if (tmo_reg == TW'(TIMEOUT_CYCLES)) begin
               abort_next = 1'b1;
               acc_next   = '0;
               state_next = WAIT_REL;
            end else
`endif
            if (deb == '0) begin
               code_next  = acc_reg;
               state_next = EMIT;
            end
         end
         EMIT: begin
            state_next = IDLE;
         end
         WAIT_REL: begin
            acc_next = '0;
            if (deb == '0) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         code_reg  <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         code_reg  <= code_next;
      end
   end

   assign code       = code_reg;
   assign code_valid = (state_reg == EMIT);
   assign busy       = (state_reg == CHORD) || (state_reg == WAIT_REL);
   assign abort      = abort_next;

endmodule
